// File: rtl/popcount_sched_if.sv
// Request/response bundle between the requesters, the popcount sequencer and the consumer of its results.
// The master side drives the requests and resp_ready. The slave side is the sequencer itself.
interface popcount_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 7
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ*2-1:0]      req_sel;
  logic                    resp_valid;
  logic [2:0]              resp_id;
  logic [2:0]              resp_count;
  logic                    resp_match;
  logic                    resp_ready;

  modport master (
    output req_valid, req_data, req_sel, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_count, resp_match
  );

  modport slave (
    input  req_valid, req_data, req_sel, resp_ready,
    output req_ready, resp_valid, resp_id, resp_count, resp_match
  );
endinterface

// File: rtl/popcount_sched.sv
// Round-robin sequencer that shares one bit-serial popcount/compare unit among N_REQ requesters.
// Each accepted word is counted one bit per cycle. The count and its match flag are then held until the consumer takes them.
module popcount_sched #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  popcount_sched_if.slave  bus,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  localparam logic [2:0]       LAST_REQ = 3'(N_REQ - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_W - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  // The match flag compares the ones in the 3-bit count against the select.
  function automatic logic match_fn(input logic [2:0] cnt, input logic [1:0] sel);
    logic [1:0] ones;
    ones = {1'b0, cnt[0]} + {1'b0, cnt[1]} + {1'b0, cnt[2]};
    return (ones == sel);
  endfunction

  // Returns {found, index} for the first valid requester at or after ptr, wrapping modulo N_REQ.
  function automatic logic [3:0] rr_pick(input logic [N_REQ-1:0] v, input logic [2:0] ptr);
    logic [3:0]       r;
    logic [N_REQ-1:0] sh;
    int               j;
    r = 4'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j  = (int'(ptr) + k) % N_REQ;
      sh = v >> j;
      if (sh[0]) begin
        r = {1'b1, 3'(j)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]        acc_q, acc_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        sel_q, sel_d;
  logic [2:0]        id_q, id_d;
  logic              resp_valid_q, resp_valid_d;
  logic [2:0]        resp_id_q, resp_id_d;
  logic [2:0]        resp_count_q, resp_count_d;
  logic              resp_match_q, resp_match_d;

  logic [3:0]        pick_s;
  logic              grant_vld_s;
  logic [2:0]        grant_idx_s;
  logic [DATA_W-1:0] word_s;
  logic [1:0]        gsel_s;
  logic [2:0]        final_cnt_s;
  logic [N_REQ-1:0]  ready_s;

  assign pick_s      = rr_pick(bus.req_valid, rr_ptr_q);
  assign grant_vld_s = pick_s[3];
  assign grant_idx_s = pick_s[2:0];
  assign word_s      = DATA_W'(bus.req_data >> (int'(grant_idx_s) * DATA_W));
  assign gsel_s      = 2'(bus.req_sel >> {grant_idx_s, 1'b0});
  // The final count includes the bit that is consumed on the edge leaving COUNT.
  assign final_cnt_s = acc_q + {2'b00, shreg_q[0]};

  // Next-state, datapath and handshake decode for the IDLE/COUNT/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    shreg_d      = shreg_q;
    acc_d        = acc_q;
    bit_d        = bit_q;
    sel_d        = sel_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_count_d = resp_count_q;
    resp_match_d = resp_match_q;
    ready_s      = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld_s && !rst) begin
          ready_s  = ONE_HOT0 << grant_idx_s;
          shreg_d  = word_s;
          sel_d    = gsel_s;
          id_d     = grant_idx_s;
          acc_d    = 3'd0;
          bit_d    = 3'd0;
          rr_ptr_d = (grant_idx_s == LAST_REQ) ? 3'd0 : grant_idx_s + 3'd1;
          state_d  = S_COUNT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COUNT: begin
        acc_d   = final_cnt_s;
        shreg_d = shreg_q >> 1;
        bit_d   = bit_q + 3'd1;
        if (bit_q == LAST_BIT) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_count_d = final_cnt_s;
          resp_match_d = match_fn(final_cnt_s, sel_q);
          resp_id_d    = id_q;
        end else begin
          state_d = S_COUNT;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= 3'd0;
      shreg_q      <= '0;
      acc_q        <= 3'd0;
      bit_q        <= 3'd0;
      sel_q        <= 2'd0;
      id_q         <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 3'd0;
      resp_count_q <= 3'd0;
      resp_match_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      shreg_q      <= shreg_d;
      acc_q        <= acc_d;
      bit_q        <= bit_d;
      sel_q        <= sel_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_count_q <= resp_count_d;
      resp_match_q <= resp_match_d;
    end
  end

  assign bus.req_ready  = ready_s;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_count = resp_count_q;
  assign bus.resp_match = resp_match_q;
  assign busy           = (state_q != S_IDLE);

endmodule
